csr_file_irq: RTL and testbench

Parametrised successor to the machine-mode CSR unit. Holds the M-mode CSR set and adds:
- 64-bit mcycle/minstret counters with mcountinhibit.
- NUM_IRQ platform interrupt lines, with priority arbitration into a registered interrupt request.
- Vectored mtvec trap-target generation.
- Illegal-access detection.

It sits beside the decode/execute stage and is the single owner of trap and CSR architectural state.

---
 rtl/riscv_defines.sv | 68 ++++++
 rtl/csr_irq_arbiter.sv | 43 ++++
 rtl/csr_file_irq.sv | 185 ++++++++++++++++++
 tb/tb_csr_file_irq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared machine-mode CSR definitions: addresses, write masks, interrupt bit
// positions and the csr_op / trap_mode encodings.
package riscv_defines;

  localparam logic [11:0] CSR_ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_ADDR_MIE           = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_ADDR_MIP           = 12'h344;
  localparam logic [11:0] CSR_ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_ADDR_MHARTID       = 12'hF14;

  // MPP is hard-wired to machine mode; only MIE and MPIE are writable.
  localparam logic [31:0] CSR_VALUE_MSTATUS      = 32'h0000_1800;
  localparam logic [31:0] CSR_MASK_MSTATUS       = 32'h0000_0088;
  localparam logic [31:0] CSR_MASK_MIE_BASE      = 32'h0000_0888;
  localparam logic [31:0] CSR_MASK_MCOUNTINHIBIT = 32'h0000_0005;
  localparam logic [31:0] CSR_MASK_MEPC          = 32'hFFFF_FFFC;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MEI_BIT          = 11;
  localparam int MTI_BIT          = 7;
  localparam int MSI_BIT          = 3;
  localparam int PLAT_IRQ_BASE    = 16;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    TRAP_NONE   = 2'd0,
    TRAP_ENTER  = 2'd1,
    TRAP_RETURN = 2'd2
  } trap_mode_e;

  typedef struct packed {
    logic        hit;
    logic        ro;
    logic [31:0] mask;
    logic [31:0] value;
  } csr_rd_t;

  function automatic logic [31:0] plat_irq_mask(input int num_irq);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < num_irq && i < 16; i++) m[PLAT_IRQ_BASE+i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt arbiter (MEI > MSI > MTI > lowest platform line)
// with registered request and cause outputs.
module csr_irq_arbiter
  import riscv_defines::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pend,
  input  logic        enable,
  output logic        irq_req_o,
  output logic [31:0] irq_cause_o
);

  logic [4:0] win_id;
  logic       req;

  always_comb begin
    win_id = 5'd0;
    if (pend[MEI_BIT])      win_id = 5'(MEI_BIT);
    else if (pend[MSI_BIT]) win_id = 5'(MSI_BIT);
    else if (pend[MTI_BIT]) win_id = 5'(MTI_BIT);
    else begin
      // Descending scan so the lowest-index pending line is the last one kept.
      for (int i = NUM_IRQ - 1; i >= 0; i--)
        if (pend[PLAT_IRQ_BASE+i]) win_id = 5'(PLAT_IRQ_BASE + i);
    end
  end

  assign req = enable & (|pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_req_o   <= 1'b0;
      irq_cause_o <= '0;
    end else begin
      irq_req_o   <= req;
      irq_cause_o <= req ? {1'b1, 26'd0, win_id} : 32'd0;
    end
  end

endmodule

// File: rtl/csr_file_irq.sv
// Machine-mode CSR file: trap state, 64-bit counters, platform interrupts
// with registered arbitration, and vectored trap-target generation.
module csr_file_irq
  import riscv_defines::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  csr_valid,
  input  logic [11:0]                           csr_addr,
  input  logic [2:0]                            csr_op,
  input  logic [31:0]                           csr_wdata,
  input  logic                                  csr_src_zero,
  output logic [31:0]                           csr_rdata,
  output logic                                  csr_illegal,
  input  logic [1:0]                            trap_mode,
  input  logic [31:0]                           trap_cause,
  input  logic [31:0]                           trap_pc,
  input  logic [31:0]                           trap_tval,
  input  logic                                  instr_retire,
  input  logic                                  irq_ext,
  input  logic                                  irq_timer,
  input  logic                                  irq_sw,
  input  logic [(NUM_IRQ > 0 ? NUM_IRQ : 1)-1:0] irq_plat,
  output logic                                  irq_req_o,
  output logic [31:0]                           irq_cause_o,
  output logic [31:0]                           trap_target_o,
  output logic [31:0]                           mepc_o
);

  localparam logic [31:0] MIE_MASK = CSR_MASK_MIE_BASE | plat_irq_mask(NUM_IRQ);
  localparam logic [31:0] CNT_MASK = COUNTERS_EN ? 32'hFFFF_FFFF : 32'h0;

  logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mip_q, mcountinhibit_q, mip_src;
  logic [63:0] mcycle_q, minstret_q, mcycle_nxt, minstret_nxt;
  csr_rd_t     rd;
  logic [31:0] op_result, wr_value;
  logic        write_intent, do_write, trap_enter, trap_ret;
  logic        unused_bits;

  assign unused_bits = ^trap_pc[1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    rd = '{hit: 1'b1, ro: (csr_addr[11:10] == 2'b11), mask: '0, value: '0};
    case (csr_addr)
      CSR_ADDR_MSTATUS:       begin rd.value = mstatus_q;        rd.mask = CSR_MASK_MSTATUS;       end
      CSR_ADDR_MIE:           begin rd.value = mie_q;            rd.mask = MIE_MASK;               end
      CSR_ADDR_MTVEC:         begin rd.value = mtvec_q;          rd.mask = '1;                     end
      CSR_ADDR_MCOUNTINHIBIT: begin rd.value = mcountinhibit_q;  rd.mask = CSR_MASK_MCOUNTINHIBIT; end
      CSR_ADDR_MSCRATCH:      begin rd.value = mscratch_q;       rd.mask = '1;                     end
      CSR_ADDR_MEPC:          begin rd.value = mepc_q;           rd.mask = CSR_MASK_MEPC;          end
      CSR_ADDR_MCAUSE:        begin rd.value = mcause_q;         rd.mask = '1;                     end
      CSR_ADDR_MTVAL:         begin rd.value = mtval_q;          rd.mask = '1;                     end
      CSR_ADDR_MIP:                 rd.value = mip_q;
      CSR_ADDR_MCYCLE:        begin rd.value = mcycle_q[31:0];   rd.mask = CNT_MASK;               end
      CSR_ADDR_MCYCLEH:       begin rd.value = mcycle_q[63:32];  rd.mask = CNT_MASK;               end
      CSR_ADDR_MINSTRET:      begin rd.value = minstret_q[31:0]; rd.mask = CNT_MASK;               end
      CSR_ADDR_MINSTRETH:     begin rd.value = minstret_q[63:32]; rd.mask = CNT_MASK;              end
      CSR_ADDR_MHARTID:             rd.value = HART_ID;
      CSR_ADDR_MVENDORID, CSR_ADDR_MARCHID, CSR_ADDR_MIMPID: rd.value = '0;
      default:                      rd.hit = 1'b0;
    endcase
  end

  always_comb begin
    op_result    = csr_wdata;
    write_intent = 1'b0;
    case (csr_op)
      CSR_OP_RW, CSR_OP_RWI: write_intent = 1'b1;
      CSR_OP_RS, CSR_OP_RSI: begin
        op_result    = rd.value | csr_wdata;
        write_intent = ~csr_src_zero;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        op_result    = rd.value & ~csr_wdata;
        write_intent = ~csr_src_zero;
      end
      default: ;
    endcase
  end

  assign csr_illegal = csr_valid & (~rd.hit | (write_intent & rd.ro));
  assign csr_rdata   = (csr_valid & ~csr_illegal) ? rd.value : 32'd0;
  assign trap_enter  = (trap_mode == TRAP_ENTER);
  assign trap_ret    = (trap_mode == TRAP_RETURN);
  assign do_write    = csr_valid & write_intent & ~csr_illegal & ~trap_enter & ~trap_ret;
  assign wr_value    = (rd.value & ~rd.mask) | (op_result & rd.mask);

  always_comb begin
    mip_src          = '0;
    mip_src[MEI_BIT] = irq_ext;
    mip_src[MTI_BIT] = irq_timer;
    mip_src[MSI_BIT] = irq_sw;
    for (int i = 0; i < NUM_IRQ; i++) mip_src[PLAT_IRQ_BASE+i] = irq_plat[i];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update in this block sees pre-edge values.
    if (rst) begin
      mstatus_q       <= CSR_VALUE_MSTATUS;
      mie_q           <= '0;
      mtvec_q         <= MTVEC_RESET;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mip_q           <= '0;
      mcountinhibit_q <= '0;
    end else begin
      mip_q <= mip_src;
      if (trap_enter) begin
        mstatus_q[MSTATUS_MPIE_BIT] <= mstatus_q[MSTATUS_MIE_BIT];
        mstatus_q[MSTATUS_MIE_BIT]  <= 1'b0;
        mepc_q                      <= {trap_pc[31:2], 2'b00};
        mcause_q                    <= trap_cause;
        mtval_q                     <= trap_tval;
      end else if (trap_ret) begin
        mstatus_q[MSTATUS_MIE_BIT]  <= mstatus_q[MSTATUS_MPIE_BIT];
        mstatus_q[MSTATUS_MPIE_BIT] <= 1'b1;
      end else if (do_write) begin
        case (csr_addr)
          CSR_ADDR_MSTATUS:       mstatus_q       <= wr_value;
          CSR_ADDR_MIE:           mie_q           <= wr_value;
          // A reserved mode (2'b1x) collapses to direct mode.
          CSR_ADDR_MTVEC:         mtvec_q         <= wr_value[1] ? {wr_value[31:2], 2'b00} : wr_value;
          CSR_ADDR_MCOUNTINHIBIT: mcountinhibit_q <= wr_value;
          CSR_ADDR_MSCRATCH:      mscratch_q      <= wr_value;
          CSR_ADDR_MEPC:          mepc_q          <= wr_value;
          CSR_ADDR_MCAUSE:        mcause_q        <= wr_value;
          CSR_ADDR_MTVAL:         mtval_q         <= wr_value;
          default: ;
        endcase
      end
    end
  end

  // A write to either half replaces the whole counter's next value, increment included.
  always_comb begin
    mcycle_nxt   = mcycle_q + (mcountinhibit_q[0] ? 64'd0 : 64'd1);
    minstret_nxt = minstret_q + ((instr_retire & ~mcountinhibit_q[2]) ? 64'd1 : 64'd0);
    if (do_write) begin
      case (csr_addr)
        CSR_ADDR_MCYCLE:    mcycle_nxt   = {mcycle_q[63:32], wr_value};
        CSR_ADDR_MCYCLEH:   mcycle_nxt   = {wr_value, mcycle_q[31:0]};
        CSR_ADDR_MINSTRET:  minstret_nxt = {minstret_q[63:32], wr_value};
        CSR_ADDR_MINSTRETH: minstret_nxt = {wr_value, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !COUNTERS_EN) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_nxt;
      minstret_q <= minstret_nxt;
    end
  end

  csr_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .pend        (mip_q & mie_q),
    .enable      (mstatus_q[MSTATUS_MIE_BIT]),
    .irq_req_o   (irq_req_o),
    .irq_cause_o (irq_cause_o)
  );

  always_comb begin
    trap_target_o = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == MTVEC_MODE_VECTORED && trap_cause[31])
      trap_target_o = {mtvec_q[31:2], 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
  end

  assign mepc_o = mepc_q;

endmodule

// File: tb/tb_csr_file_irq.sv
// Bench for csr_file_irq: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an architectural CSR model.
module tb_csr_file_irq;

  localparam int NUM_IRQ = 4;

  logic        clk = 1'b0;
  logic        rst, csr_valid, csr_src_zero, instr_retire, irq_ext, irq_timer, irq_sw;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [1:0]  trap_mode;
  logic [31:0] csr_wdata, trap_cause, trap_pc, trap_tval;
  logic [NUM_IRQ-1:0] irq_plat;
  logic [31:0] csr_rdata, irq_cause_o, trap_target_o, mepc_o;
  logic        csr_illegal, irq_req_o;

  always #5 clk = ~clk;

  csr_file_irq #(
    .HART_ID(32'd3), .NUM_IRQ(NUM_IRQ), .MTVEC_RESET(32'h0), .COUNTERS_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .trap_mode(trap_mode), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .instr_retire(instr_retire),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw), .irq_plat(irq_plat),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .trap_target_o(trap_target_o),
    .mepc_o(mepc_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model state
  bit        m_valid = 1'b0;
  bit        m_ie, m_pie, m_req;
  bit [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_inhibit, m_cause;
  bit [63:0] m_cycle, m_instret;

  function automatic bit m_exists(input bit [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] m_read(input bit [11:0] a);
    case (a)
      12'h300: return {19'd0, 2'b11, 3'd0, m_pie, 3'd0, m_ie, 3'd0};
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h320: return m_inhibit;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [31:0] m_mask(input bit [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h000F_0888;
      12'h320: return 32'h0000_0005;
      12'h341: return 32'hFFFF_FFFC;
      12'h305, 12'h340, 12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_intent(input bit [2:0] op, input bit sz);
    if (op == 3'd1 || op == 3'd5) return 1'b1;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6 || op == 3'd7) return !sz;
    return 1'b0;
  endfunction

  function automatic bit m_illegal();
    return csr_valid && (!m_exists(csr_addr) ||
                         (m_intent(csr_op, csr_src_zero) && csr_addr[11:10] == 2'b11));
  endfunction

  task automatic compare();
    bit        ill;
    bit [31:0] base, tgt;
    if (!m_valid) return;
    ill = m_illegal();
    check("csr_illegal", csr_illegal, ill);
    check("csr_rdata", csr_rdata, (csr_valid && !ill) ? m_read(csr_addr) : 32'd0);
    base = m_mtvec & ~32'd3;
    tgt  = (m_mtvec[1:0] == 2'b01 && trap_cause[31]) ? base + 4 * trap_cause[4:0] : base;
    check("trap_target_o", trap_target_o, tgt);
    check("mepc_o", mepc_o, m_mepc);
    check("irq_req_o", irq_req_o, m_req);
    check("irq_cause_o", irq_cause_o, m_cause);
  endtask

  task automatic model_update();
    bit [31:0] pend, old, res, nv, id;
    bit [63:0] cyc, ins;
    bit        req;
    if (rst) begin
      m_ie = 0; m_pie = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_mip = 0; m_inhibit = 0; m_cycle = 0; m_instret = 0;
      m_req = 0; m_cause = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    pend = m_mip & m_mie;
    req  = m_ie && (pend != 0);
    id   = 0;
    if (pend[11]) id = 11;
    else if (pend[3]) id = 3;
    else if (pend[7]) id = 7;
    else for (int i = 19; i >= 16; i--) if (pend[i]) id = i;
    cyc = m_cycle + (m_inhibit[0] ? 0 : 1);
    ins = m_instret + ((instr_retire && !m_inhibit[2]) ? 1 : 0);
    if (trap_mode == 2'd1) begin
      m_pie = m_ie; m_ie = 0;
      m_mepc = trap_pc & ~32'd3; m_mcause = trap_cause; m_mtval = trap_tval;
    end else if (trap_mode == 2'd2) begin
      m_ie = m_pie; m_pie = 1;
    end else if (csr_valid && m_intent(csr_op, csr_src_zero) && !m_illegal()) begin
      old = m_read(csr_addr);
      case (csr_op)
        3'd2, 3'd6: res = old | csr_wdata;
        3'd3, 3'd7: res = old & ~csr_wdata;
        default:    res = csr_wdata;
      endcase
      nv = (old & ~m_mask(csr_addr)) | (res & m_mask(csr_addr));
      case (csr_addr)
        12'h300: begin m_pie = nv[7]; m_ie = nv[3]; end
        12'h304: m_mie = nv;
        12'h305: m_mtvec = nv[1] ? (nv & ~32'd3) : nv;
        12'h320: m_inhibit = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: cyc = {m_cycle[63:32], nv};
        12'hB80: cyc = {nv, m_cycle[31:0]};
        12'hB02: ins = {m_instret[63:32], nv};
        12'hB82: ins = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle   = cyc;
    m_instret = ins;
    m_mip     = {12'd0, irq_plat, 4'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};
    m_req     = req;
    m_cause   = req ? (32'h8000_0000 | id) : 32'd0;
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic tick();
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic csr(input bit [11:0] a, input bit [2:0] op, input bit [31:0] d, input bit sz);
    csr_valid = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d; csr_src_zero = sz;
  endtask

  task automatic idle();
    csr_valid = 1'b0; csr_addr = 12'h0; csr_op = 3'd0; csr_wdata = 32'd0; csr_src_zero = 1'b0;
  endtask

  bit [11:0] addrs [20] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                            12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                            12'hF14, 12'hC00, 12'h7C0, 12'h345, 12'hF15, 12'h301};

  initial begin
    int r;
    rst = 1'b1; idle(); trap_mode = 2'd0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    instr_retire = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0; irq_plat = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    check("reset irq_req", irq_req_o, 0);
    check("reset irq_cause", irq_cause_o, 0);
    check("reset mepc", mepc_o, 0);
    csr(12'h300, 3'd2, 0, 1); #1 check("reset mstatus", csr_rdata, 32'h1800); tick();

    csr(12'hF14, 3'd2, 0, 1); #1 check("mhartid read", csr_rdata, 3);
    check("mhartid rs zero legal", csr_illegal, 0); tick();
    csr(12'hF14, 3'd1, 5, 0); #1 check("mhartid write illegal", csr_illegal, 1);
    check("illegal rdata", csr_rdata, 0); tick();
    csr(12'hF14, 3'd2, 0, 1); #1 check("mhartid kept", csr_rdata, 3); tick();

    csr(12'h305, 3'd1, 32'h2002, 0); tick();
    csr(12'h305, 3'd2, 0, 1); #1 check("mtvec mode masked", csr_rdata, 32'h2000); tick();
    csr(12'h305, 3'd1, 32'h1001, 0); tick();
    csr(12'h340, 3'd1, 32'h1234, 0); tick();
    idle(); trap_cause = 32'h8000_0007;
    #1 check("vectored target", trap_target_o, 32'h101C);
    trap_cause = 32'h2;
    #1 check("exception target", trap_target_o, 32'h1000); tick();

    csr(12'h304, 3'd1, 32'h0001_0880, 0); tick();
    csr(12'h300, 3'd2, 32'h8, 0); tick();
    idle(); irq_timer = 1; irq_plat = 4'b0001; tick();
    check("irq after one edge", irq_req_o, 0); tick();
    check("irq after two edges", irq_req_o, 1);
    check("timer cause", irq_cause_o, 32'h8000_0007);
    irq_ext = 1; tick();
    check("ext one edge", irq_cause_o, 32'h8000_0007); tick();
    check("ext cause", irq_cause_o, 32'h8000_000B);

    csr(12'h340, 3'd1, 32'hDEAD, 0);
    trap_mode = 2'd1; trap_pc = 32'h203; trap_cause = 32'h8000_000B; trap_tval = 32'h55; tick();
    trap_mode = 2'd0; csr(12'h300, 3'd2, 0, 1);
    #1 check("mepc aligned", mepc_o, 32'h200);
    check("mstatus after enter", csr_rdata, 32'h1880);
    check("irq_req at trap edge", irq_req_o, 1); tick();
    check("irq_req after enter", irq_req_o, 0);
    csr(12'h340, 3'd2, 0, 1); #1 check("mscratch kept", csr_rdata, 32'h1234); tick();
    csr(12'h342, 3'd2, 0, 1); #1 check("mcause", csr_rdata, 32'h8000_000B); tick();
    idle(); trap_mode = 2'd2; tick();
    trap_mode = 2'd0; csr(12'h300, 3'd2, 0, 1); #1 check("mstatus after return", csr_rdata, 32'h1888); tick();

    csr(12'hB00, 3'd1, 32'hFFFF_FFFF, 0); tick();
    csr(12'hB80, 3'd1, 32'h0, 0); tick();
    csr(12'hB80, 3'd2, 0, 1); #1 check("mcycleh before carry", csr_rdata, 0); tick();
    csr(12'hB80, 3'd2, 0, 1); #1 check("mcycleh after carry", csr_rdata, 1); tick();
    csr(12'h320, 3'd1, 32'h1, 0); tick();
    csr(12'hB00, 3'd2, 0, 1); #1 check("mcycle frozen a", csr_rdata, 2); tick();
    csr(12'hB00, 3'd2, 0, 1); #1 check("mcycle frozen b", csr_rdata, 2); tick();
    idle(); instr_retire = 1; repeat (5) tick();
    instr_retire = 0; csr(12'hB02, 3'd2, 0, 1); #1 check("minstret +5", csr_rdata, 5); tick();
    csr(12'h320, 3'd1, 32'h0, 0); tick();

    check("irq pending before reset", irq_req_o, 1);
    rst = 1'b1; csr(12'h340, 3'd1, 32'h5555, 0); tick();
    rst = 1'b0;
    check("rst irq_req", irq_req_o, 0);
    check("rst irq_cause", irq_cause_o, 0);
    check("rst mepc", mepc_o, 0);
    csr(12'h340, 3'd2, 0, 1); #1 check("rst write dropped", csr_rdata, 0); tick();

    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      csr_valid    = ($urandom_range(0, 3) != 0);
      csr_addr     = addrs[$urandom_range(0, 19)];
      csr_op       = 3'($urandom_range(0, 7));
      csr_wdata    = $urandom;
      csr_src_zero = ($urandom_range(0, 3) == 0);
      r            = $urandom_range(0, 19);
      trap_mode    = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
      trap_cause   = $urandom;
      trap_pc      = $urandom;
      trap_tval    = $urandom;
      instr_retire = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) {irq_ext, irq_timer, irq_sw, irq_plat} = 7'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
